instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Turns one field-level instruction request into a packed 32-bit word group: optional I prefix, optional T prefix, then the main word.
//  The main word is D, W or fragment start/end.
//  Sits between the CGRA configuration/program generator and instruction memory/fetch; it is the inverse of the instruction decoder.
//  A word stream it emits must decode back to the original fields.
// PARAMETERS
//  CNT_W          16  width of the emitted-word counter
//  IPREFIX_ALWAYS 0   1: always emit I prefix for D/W; 0: only when imm[31:6]!=0
// PORTS
//  clk         in  1   clock, all logic on rising edge
//  rst         in  1   synchronous reset, active-high
//  in_valid    in  1   request valid
//  in_ready    out 1   request accepted when in_valid&&in_ready
//  in_kind     in  2   00=D 01=W 10=FRAG 11=illegal
//  in_op0      in  1   D only: selects opcode 000 (0) / 001 (1)
//  in_funct    in  4   funct (D/W)
//  in_immab    in  1   immab (D/W)
//  in_imm      in  32  full immediate; imm[5:0]->immlo, imm[31:6]->immhi
//  in_use_t    in  1   D only: emit T prefix carrying ta3/tt3/ta4/tt4
//  in_ta1..4   in  6   target addresses
//  in_tt1..4   in  2   target types
//  in_offset   in  10  W offset
//  in_endf     in  1   FRAG end flag
//  in_nalloc   in  7   FRAG allocation count
//  out_valid   out 1   out_word valid
//  out_ready   in  1   downstream accepts word when out_valid&&out_ready
//  out_word    out 32  encoded word
//  out_last    out 1   high on final word of a group
//  err_illegal out 1   1-cycle pulse when kind=11 accepted
//  words_out   out CNT_W  count of words handshaken out; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_word=0, out_last=0, err_illegal=0, words_out=0; in_ready=1 the cycle after reset.
//  FSM states: IDLE, EMIT_I, EMIT_T, EMIT_MAIN. in_ready = (state==IDLE), combinational.
//  On accept: all fields are latched.
//   needI = (kind D/W) && (IPREFIX_ALWAYS || imm[31:6]!=0).
//   needT = (kind D) && in_use_t.
//   First word is loaded into the output register next cycle: I if needI, else T if needT, else main.
//  Order is always I -> T -> main. out_last=1 only with the main word.
//  Word advance: on out_valid&&out_ready, load the next word, or go to IDLE with out_valid=0 after the main word.
//  No input is accepted until IDLE. Group of N words occupies N+1 cycles minimum.
//  Backpressure: while out_valid&&!out_ready, out_word, out_last and state are held stable.
//  Encodings (unlisted bits 0):
//   D:    [31:29]={2'b00,op0} [28:25]funct [24]immab [23:18]imm[5:0] [15:14]tt2 [13:8]ta2 [7:6]tt1 [5:0]ta1
//   W:    [31:29]=010 [28:25]funct [24]immab [23:18]imm[5:0] [9:0]offset
//   T:    [31:29]=011 [15:14]tt4 [13:8]ta4 [7:6]tt3 [5:0]ta3
//   I:    [31:29]=100 [25:0]imm[31:6]
//   FRAG: [31:29]=101 [28]endf [6:0]nalloc
//  Ignored fields: in_use_t ignored for W/FRAG; imm ignored for FRAG.
//  kind=11: accepted (in_ready was high) and nothing emitted; err_illegal=1 next cycle; state stays IDLE.
//  words_out increments on every out handshake, including prefixes.
//  Reset mid-group: the group is discarded, out_valid=0 the following cycle, no partial words resume.
// TESTING
//  D op0=1 funct=3 immab=1 imm=5 ta1=0x0A tt1=2 ta2=0x15 tt2=1, use_t=0 -> one word 0x2714558A, last=1, words_out=1.
//  D op0=0 imm=0x1234 use_t=1 ta3=3 tt3=1 ta4=4 tt4=3, other fields 0 ->
//   0x80000048, then 0x6000C443, then 0x00D00000 (last only on third).
//  W funct=2 imm=0 offset=0x3FF -> 0x440003FF.
//  FRAG endf=1 nalloc=0x45 -> 0xB0000045.
//  Case 2 with out_ready low 3 cycles on the T word -> out_word stays 0x6000C443, in_ready=0, words_out unchanged.
//  kind=11 -> no out_valid, err_illegal single pulse, in_ready stays 1.
//  IPREFIX_ALWAYS=1, D imm=0 -> 0x80000000 then the main word.
//  rst asserted after the I word of case 2 -> out_valid=0 next cycle, words_out=0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: turns one field-level request into an I/T-prefixed word group.
// It is the inverse of the instruction decoder; emitted words decode back to the request fields.
//
// state     | meaning
// IDLE      | waiting for a request, in_ready high
// EMIT_I    | presenting the I prefix (imm[31:6])
// EMIT_T    | presenting the T prefix (ta3/tt3/ta4/tt4)
// EMIT_MAIN | presenting the main D/W/FRAG word, out_last high
module instr_encoder #(
    parameter int CNT_W          = 16,
    parameter bit IPREFIX_ALWAYS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic             in_op0,
    input  logic [3:0]       in_funct,
    input  logic             in_immab,
    input  logic [31:0]      in_imm,
    input  logic             in_use_t,
    input  logic [5:0]       in_ta1,
    input  logic [5:0]       in_ta2,
    input  logic [5:0]       in_ta3,
    input  logic [5:0]       in_ta4,
    input  logic [1:0]       in_tt1,
    input  logic [1:0]       in_tt2,
    input  logic [1:0]       in_tt3,
    input  logic [1:0]       in_tt4,
    input  logic [9:0]       in_offset,
    input  logic             in_endf,
    input  logic [6:0]       in_nalloc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last,
    output logic             err_illegal,
    output logic [CNT_W-1:0] words_out
);

    localparam logic [1:0] KIND_D    = 2'b00;
    localparam logic [1:0] KIND_W    = 2'b01;
    localparam logic [1:0] KIND_FRAG = 2'b10;
    localparam logic [1:0] KIND_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT_I    = 2'd1,
        EMIT_T    = 2'd2,
        EMIT_MAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  kind_q;
    logic        op0_q;
    logic [3:0]  funct_q;
    logic        immab_q;
    logic [31:0] imm_q;
    logic        need_t_q;
    logic [5:0]  ta1_q, ta2_q, ta3_q, ta4_q;
    logic [1:0]  tt1_q, tt2_q, tt3_q, tt4_q;
    logic [9:0]  offset_q;
    logic        endf_q;
    logic [6:0]  nalloc_q;

    logic        accept;
    logic        is_dw;
    logic        need_i;
    logic        need_t;
    logic        out_fire;
    logic [31:0] word_d;
    logic [31:0] word_w;
    logic [31:0] word_t;
    logic [31:0] word_i;
    logic [31:0] word_frag;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_dw    = (in_kind == KIND_D) || (in_kind == KIND_W);
    assign need_i   = is_dw && (IPREFIX_ALWAYS || (in_imm[31:6] != 26'd0));
    assign need_t   = (in_kind == KIND_D) && in_use_t;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request fields are captured only on accept and stay stable for the whole group.
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q   <= KIND_D;
            op0_q    <= 1'b0;
            funct_q  <= 4'd0;
            immab_q  <= 1'b0;
            imm_q    <= 32'd0;
            need_t_q <= 1'b0;
            ta1_q    <= 6'd0;
            ta2_q    <= 6'd0;
            ta3_q    <= 6'd0;
            ta4_q    <= 6'd0;
            tt1_q    <= 2'd0;
            tt2_q    <= 2'd0;
            tt3_q    <= 2'd0;
            tt4_q    <= 2'd0;
            offset_q <= 10'd0;
            endf_q   <= 1'b0;
            nalloc_q <= 7'd0;
        end else if (accept) begin
            kind_q   <= in_kind;
            op0_q    <= in_op0;
            funct_q  <= in_funct;
            immab_q  <= in_immab;
            imm_q    <= in_imm;
            need_t_q <= need_t;
            ta1_q    <= in_ta1;
            ta2_q    <= in_ta2;
            ta3_q    <= in_ta3;
            ta4_q    <= in_ta4;
            tt1_q    <= in_tt1;
            tt2_q    <= in_tt2;
            tt3_q    <= in_tt3;
            tt4_q    <= in_tt4;
            offset_q <= in_offset;
            endf_q   <= in_endf;
            nalloc_q <= in_nalloc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
            words_out   <= '0;
        end else begin
            err_illegal <= accept && (in_kind == KIND_ILL);
            if (out_fire) begin
                words_out <= words_out + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && (in_kind != KIND_ILL)) begin
                    if (need_i) begin
                        state_nx = EMIT_I;
                    end else if (need_t) begin
                        state_nx = EMIT_T;
                    end else begin
                        state_nx = EMIT_MAIN;
                    end
                end
            end
            EMIT_I: begin
                if (out_ready) begin
                    state_nx = need_t_q ? EMIT_T : EMIT_MAIN;
                end
            end
            EMIT_T: begin
                if (out_ready) begin
                    state_nx = EMIT_MAIN;
                end
            end
            EMIT_MAIN: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        word_d    = {2'b00, op0_q, funct_q, immab_q, imm_q[5:0], 2'b00,
                     tt2_q, ta2_q, tt1_q, ta1_q};
        word_w    = {3'b010, funct_q, immab_q, imm_q[5:0], 8'd0, offset_q};
        word_t    = {3'b011, 13'd0, tt4_q, ta4_q, tt3_q, ta3_q};
        word_i    = {3'b100, 3'b000, imm_q[31:6]};
        word_frag = {3'b101, endf_q, 21'd0, nalloc_q};
    end

    always_comb begin
        out_valid = 1'b0;
        out_word  = 32'd0;
        out_last  = 1'b0;
        case (state)
            EMIT_I: begin
                out_valid = 1'b1;
                out_word  = word_i;
            end
            EMIT_T: begin
                out_valid = 1'b1;
                out_word  = word_t;
            end
            EMIT_MAIN: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                case (kind_q)
                    KIND_W:    out_word = word_w;
                    KIND_FRAG: out_word = word_frag;
                    default:   out_word = word_d;
                endcase
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed spec vectors, backpressure, reset mid-group,
// then randomized requests checked against a word-list reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid_a;
    logic        in_ready, in_ready_a;
    logic [1:0]  in_kind;
    logic        in_op0;
    logic [3:0]  in_funct;
    logic        in_immab;
    logic [31:0] in_imm;
    logic        in_use_t;
    logic [5:0]  in_ta1, in_ta2, in_ta3, in_ta4;
    logic [1:0]  in_tt1, in_tt2, in_tt3, in_tt4;
    logic [9:0]  in_offset;
    logic        in_endf;
    logic [6:0]  in_nalloc;
    logic        out_valid, out_valid_a;
    logic        out_ready, out_ready_a;
    logic [31:0] out_word, out_word_a;
    logic        out_last, out_last_a;
    logic        err_illegal, err_illegal_a;
    logic [15:0] words_out, words_out_a;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_cnt;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16), .IPREFIX_ALWAYS(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_op0(in_op0), .in_funct(in_funct), .in_immab(in_immab),
        .in_imm(in_imm), .in_use_t(in_use_t),
        .in_ta1(in_ta1), .in_ta2(in_ta2), .in_ta3(in_ta3), .in_ta4(in_ta4),
        .in_tt1(in_tt1), .in_tt2(in_tt2), .in_tt3(in_tt3), .in_tt4(in_tt4),
        .in_offset(in_offset), .in_endf(in_endf), .in_nalloc(in_nalloc),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .err_illegal(err_illegal), .words_out(words_out)
    );

    instr_encoder #(.CNT_W(16), .IPREFIX_ALWAYS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_kind(in_kind), .in_op0(in_op0), .in_funct(in_funct), .in_immab(in_immab),
        .in_imm(in_imm), .in_use_t(in_use_t),
        .in_ta1(in_ta1), .in_ta2(in_ta2), .in_ta3(in_ta3), .in_ta4(in_ta4),
        .in_tt1(in_tt1), .in_tt2(in_tt2), .in_tt3(in_tt3), .in_tt4(in_tt4),
        .in_offset(in_offset), .in_endf(in_endf), .in_nalloc(in_nalloc),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_word(out_word_a),
        .out_last(out_last_a), .err_illegal(err_illegal_a), .words_out(words_out_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_fields();
        in_kind = 2'b00; in_op0 = 1'b0; in_funct = 4'd0; in_immab = 1'b0;
        in_imm = 32'd0; in_use_t = 1'b0;
        in_ta1 = 6'd0; in_ta2 = 6'd0; in_ta3 = 6'd0; in_ta4 = 6'd0;
        in_tt1 = 2'd0; in_tt2 = 2'd0; in_tt3 = 2'd0; in_tt4 = 2'd0;
        in_offset = 10'd0; in_endf = 1'b0; in_nalloc = 7'd0;
    endtask

    // Reference model: the list of words a request should produce, from the field layout.
    task automatic build_exp(input bit alw);
        logic [31:0] common;
        exp_q.delete();
        if (in_kind == 2'b10) begin
            exp_q.push_back(32'hA000_0000 | (32'(in_endf) << 28) | 32'(in_nalloc));
        end else if (in_kind != 2'b11) begin
            if (alw || (in_imm / 64) != 0)
                exp_q.push_back(32'h8000_0000 | (in_imm / 64));
            if (in_kind == 2'b00 && in_use_t)
                exp_q.push_back(32'h6000_0000 | (32'(in_tt4) << 14) | (32'(in_ta4) << 8)
                                | (32'(in_tt3) << 6) | 32'(in_ta3));
            common = (32'(in_funct) << 25) | (32'(in_immab) << 24) | ((in_imm % 64) << 18);
            if (in_kind == 2'b00)
                exp_q.push_back((32'(in_op0) << 29) | common | (32'(in_tt2) << 14)
                                | (32'(in_ta2) << 8) | (32'(in_tt1) << 6) | 32'(in_ta1));
            else
                exp_q.push_back(32'h4000_0000 | common | 32'(in_offset));
        end
    endtask

    // Sends the current request to dut and drains exp_q with random backpressure.
    task automatic run_group(input int pct, input int stall_idx, input int stall_n);
        int n;
        int stall;
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            stall = 0;
            for (int c = 0; c < 64; c++) begin
                if (i == stall_idx && stall < stall_n) out_ready = 1'b0;
                else if (stall >= 6) out_ready = 1'b1;
                else out_ready = ($urandom_range(0, 99) < pct);
                chk("valid", out_valid, 1);
                chk("word", out_word, exp_q[i]);
                chk("last", out_last, 32'(i == n - 1));
                chk("busy", in_ready, 0);
                chk("cnt", words_out, exp_cnt);
                step();
                if (out_ready) begin
                    exp_cnt++;
                    break;
                end
                stall++;
            end
        end
        out_ready = 1'b0;
        chk("done_valid", out_valid, 0);
        chk("done_ready", in_ready, 1);
        chk("done_cnt", words_out, exp_cnt);
    endtask

    task automatic run_illegal();
        chk("ill_ready0", in_ready, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ill_pulse", err_illegal, 1);
        chk("ill_novalid", out_valid, 0);
        chk("ill_ready1", in_ready, 1);
        step();
        chk("ill_pulse_end", err_illegal, 0);
        chk("ill_novalid2", out_valid, 0);
        chk("ill_cnt", words_out, exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_valid_a = 1'b0;
        out_ready = 1'b0; out_ready_a = 1'b0;
        exp_cnt = 16'd0;
        clear_fields();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_word, 0);
        chk("rst_last", out_last, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_cnt", words_out, 0);
        rst = 1'b0;
        step();
        chk("rst_ready", in_ready, 1);

        // Case 1: single D word
        clear_fields();
        in_op0 = 1'b1; in_funct = 4'd3; in_immab = 1'b1; in_imm = 32'd5;
        in_ta1 = 6'h0A; in_tt1 = 2'd2; in_ta2 = 6'h15; in_tt2 = 2'd1;
        exp_q = '{32'h2714_558A};
        run_group(100, -1, 0);
        chk("case1_cnt", words_out, 1);

        // Case 2: I, T, main
        clear_fields();
        in_imm = 32'h1234; in_use_t = 1'b1;
        in_ta3 = 6'd3; in_tt3 = 2'd1; in_ta4 = 6'd4; in_tt4 = 2'd3;
        exp_q = '{32'h8000_0048, 32'h6000_C443, 32'h00D0_0000};
        run_group(100, -1, 0);

        // Case 3: W and case 4: FRAG
        clear_fields();
        in_kind = 2'b01; in_funct = 4'd2; in_offset = 10'h3FF; in_use_t = 1'b1;
        exp_q = '{32'h4400_03FF};
        run_group(100, -1, 0);
        clear_fields();
        in_kind = 2'b10; in_endf = 1'b1; in_nalloc = 7'h45; in_imm = 32'hFFFF_FFFF;
        exp_q = '{32'hB000_0045};
        run_group(100, -1, 0);

        // Case 2 with the T word held off for three cycles
        clear_fields();
        in_imm = 32'h1234; in_use_t = 1'b1;
        in_ta3 = 6'd3; in_tt3 = 2'd1; in_ta4 = 6'd4; in_tt4 = 2'd3;
        exp_q = '{32'h8000_0048, 32'h6000_C443, 32'h00D0_0000};
        run_group(100, 1, 3);

        in_kind = 2'b11;
        run_illegal();

        // Reset after the I word has been handshaken
        clear_fields();
        in_imm = 32'h1234; in_use_t = 1'b1;
        in_ta3 = 6'd3; in_tt3 = 2'd1; in_ta4 = 6'd4; in_tt4 = 2'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("mid_iword", out_word, 32'h8000_0048);
        step();
        chk("mid_tword", out_word, 32'h6000_C443);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        exp_cnt = 16'd0;
        chk("mid_valid", out_valid, 0);
        chk("mid_cnt", words_out, 0);
        chk("mid_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("mid_noresume", out_valid, 0);
        out_ready = 1'b0;

        // Forced I prefix on the second instance, same request on the default one
        clear_fields();
        in_funct = 4'd5; in_ta1 = 6'd7;
        in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        chk("alw_iword", out_word_a, 32'h8000_0000);
        chk("alw_ilast", out_last_a, 0);
        step();
        chk("alw_main", out_word_a, 32'h0A00_0007);
        chk("alw_mlast", out_last_a, 1);
        step();
        chk("alw_done", out_valid_a, 0);
        chk("alw_cnt", words_out_a, 2);
        chk("alw_err", err_illegal_a, 0);
        chk("alw_ready", in_ready_a, 1);
        out_ready_a = 1'b0;
        exp_q = '{32'h0A00_0007};
        run_group(100, -1, 0);

        // Randomized requests against the reference model
        for (int r = 0; r < 60; r++) begin
            in_kind = 2'($urandom_range(0, 3));
            in_op0 = 1'($urandom); in_funct = 4'($urandom); in_immab = 1'($urandom);
            in_imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            in_use_t = 1'($urandom);
            in_ta1 = 6'($urandom); in_ta2 = 6'($urandom); in_ta3 = 6'($urandom); in_ta4 = 6'($urandom);
            in_tt1 = 2'($urandom); in_tt2 = 2'($urandom); in_tt3 = 2'($urandom); in_tt4 = 2'($urandom);
            in_offset = 10'($urandom); in_endf = 1'($urandom); in_nalloc = 7'($urandom);
            if (in_kind == 2'b11) begin
                run_illegal();
            end else begin
                build_exp(1'b0);
                run_group(60, -1, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
